// File: rtl/adler32_stream_if.sv
// Adler-32 stream engine handshake bundle.
// Input beat channel plus checksum result channel.
interface adler32_stream_if #(
  parameter int LANES = 4
) ();
  localparam int NB_W = $clog2(LANES + 1);

  logic                 in_valid;
  logic                 in_ready;
  logic [8*LANES-1:0]   in_data;
  logic [NB_W-1:0]      in_nbytes;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          out_checksum;

  modport master (
    output in_valid,
    output in_data,
    output in_nbytes,
    output in_last,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_checksum
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_nbytes,
    input  in_last,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_checksum
  );
endinterface

// File: rtl/adler32_stream.sv
// Streaming Adler-32 engine, LANES bytes per beat.
// One-cycle reduction; holds a single pending checksum.
module adler32_stream #(
  parameter int LANES = 4
) (
  input logic           clk,
  input logic           rst,
  adler32_stream_if.slave s
);
  localparam int NB_W = $clog2(LANES + 1);
  localparam logic [16:0] MOD = 17'd65521;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [31:0] chk_q, chk_d;

  logic        acc;
  int          kk;
  logic [25:0] dsum;
  logic [25:0] wsum;
  logic [25:0] a_sum;
  logic [25:0] b_sum;
  logic [15:0] a_new;
  logic [15:0] b_new;

  // 2^16 = 15 mod 65521, so fold the high part
  // once and finish with one conditional subtract.
  function automatic logic [15:0] mod_red(
    input logic [25:0] x
  );
    logic [16:0] t;
    t = 17'(x[15:0]) + 17'(x[25:16]) * 17'd15;
    if (t >= MOD) begin
      t = t - MOD;
    end
    return t[15:0];
  endfunction

  assign acc            = s.in_valid & s.in_ready;
  assign s.in_ready     = (state_q == ACCUM);
  assign s.out_valid    = (state_q == DONE);
  assign s.out_checksum = chk_q;

  // Per-beat A/B update at full width, then reduce.
  always_comb begin
    kk = int'(s.in_nbytes);
    if (kk > LANES) begin
      kk = LANES;
    end
    dsum = '0;
    wsum = '0;
    for (int i = 0; i < LANES; i++) begin
      if (i < kk) begin
        dsum = dsum + 26'(s.in_data[8*i +: 8]);
        wsum = wsum + 26'(kk - i)
                    * 26'(s.in_data[8*i +: 8]);
      end
    end
    a_sum = 26'(a_q) + dsum;
    b_sum = 26'(b_q) + 26'(kk) * 26'(a_q) + wsum;
    a_new = mod_red(a_sum);
    b_new = mod_red(b_sum);
  end

  // Next state: accumulate, publish on last beat,
  // release on the output handshake.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    chk_d   = chk_q;
    unique case (state_q)
      ACCUM: begin
        if (acc) begin
          if (s.in_last) begin
            a_d     = 16'd1;
            b_d     = 16'd0;
            chk_d   = {b_new, a_new};
            state_d = DONE;
          end else begin
            a_d = a_new;
            b_d = b_new;
          end
        end
      end
      DONE: begin
        if (s.out_ready) begin
          state_d = ACCUM;
        end
      end
      default: begin
        state_d = ACCUM;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      a_q     <= 16'd1;
      b_q     <= 16'd0;
      chk_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      chk_q   <= chk_d;
    end
  end
endmodule

// File: tb/tb_adler32_stream.sv
// Bench for adler32_stream: scoreboarded messages
// on a LANES=4 unit plus long runs at LANES 1/4/8.
module tb_adler32_stream;
  localparam int LONG_N = 6003;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  logic [31:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  function automatic logic [31:0] adler_step(
    input logic [31:0] st,
    input logic [7:0]  d
  );
    int a;
    int b;
    a = int'(st[15:0]);
    b = int'(st[31:16]);
    a = (a + int'(d)) % 65521;
    b = (b + a) % 65521;
    return {b[15:0], a[15:0]};
  endfunction

  adler32_stream_if #(.LANES(4)) m ();

  adler32_stream #(.LANES(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .s   (m.slave)
  );

  always @(negedge clk) begin
    if (!rst && m.out_valid && m.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious", 32'(exp_q.size()), 32'd1);
      end else begin
        chk("cksum", m.out_checksum,
            exp_q.pop_front());
      end
    end
  end

  task automatic send_beat(
    input logic [31:0] data,
    input int          nb,
    input logic        last,
    input int          bub
  );
    int n;
    bit ok;
    repeat (bub) begin
      @(posedge clk);
      #1;
    end
    m.in_valid  = 1'b1;
    m.in_data   = data;
    m.in_nbytes = 3'(nb);
    m.in_last   = last;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 50) begin
      @(negedge clk);
      if (m.in_ready) ok = 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) chk("accept_to", 32'(n), 32'd0);
    m.in_valid = 1'b0;
    m.in_data  = $urandom;
    m.in_last  = 1'b0;
  endtask

  task automatic send_str(
    input string       str,
    input int          bub,
    input logic [31:0] exp,
    input bit          push
  );
    int          i;
    int          nb;
    logic [31:0] d;
    if (push) exp_q.push_back(exp);
    if (str.len() == 0) begin
      send_beat($urandom, 0, 1'b1, bub);
    end
    i = 0;
    while (i < str.len()) begin
      nb = str.len() - i;
      if (nb > 4) nb = 4;
      for (int j = 0; j < 4; j++) begin
        if (j < nb) d[8*j +: 8] = str[i+j];
        else        d[8*j +: 8] = 8'($urandom);
      end
      send_beat(d, nb, (i + nb >= str.len()),
                (i == 0) ? 0 : bub);
      i += nb;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0)
      chk("drain_to", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_long
    localparam int L  = (g == 0) ? 1 :
                        (g == 1) ? 4 : 8;
    localparam int NB = $clog2(L + 1);
    logic        lrst;
    bit          done;
    logic [31:0] q[$];

    adler32_stream_if #(.LANES(L)) li ();

    adler32_stream #(.LANES(L)) u_dut (
      .clk (clk),
      .rst (lrst),
      .s   (li.slave)
    );

    always @(negedge clk) begin
      if (!lrst && li.out_valid && li.out_ready) begin
        if (q.size() == 0) begin
          chk("long_spurious", 32'(q.size()), 32'd1);
        end else begin
          chk("long_cksum", li.out_checksum,
              q.pop_front());
        end
      end
    end

    initial begin
      int             sent;
      int             nb;
      int             n;
      bit             ok;
      logic [31:0]    r;
      logic [8*L-1:0] d;
      done         = 1'b0;
      lrst         = 1'b1;
      li.in_valid  = 1'b0;
      li.in_data   = '0;
      li.in_nbytes = '0;
      li.in_last   = 1'b0;
      li.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      lrst = 1'b0;
      r = 32'd1;
      for (int i = 0; i < LONG_N; i++)
        r = adler_step(r, 8'hFF);
      q.push_back(r);
      sent = 0;
      while (sent < LONG_N) begin
        nb = LONG_N - sent;
        if (nb > L) nb = L;
        for (int j = 0; j < L; j++) begin
          if (j < nb) d[8*j +: 8] = 8'hFF;
          else        d[8*j +: 8] = 8'($urandom);
        end
        li.in_data  = d;
        li.in_valid = 1'b1;
        li.in_last  = (sent + nb >= LONG_N);
        if (sent == 0)
          li.in_nbytes = NB'((1 << NB) - 1);
        else
          li.in_nbytes = NB'(nb);
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 50) begin
          @(negedge clk);
          if (li.in_ready) ok = 1'b1;
          @(posedge clk);
          #1;
          n++;
        end
        if (!ok) begin
          chk("long_accept_to", 32'(n), 32'd0);
          sent = LONG_N;
        end
        sent += nb;
      end
      li.in_valid = 1'b0;
      n = 0;
      while (q.size() != 0 && n < 100) begin
        @(posedge clk);
        n++;
      end
      if (q.size() != 0)
        chk("long_drain_to", 32'(q.size()), 32'd0);
      done = 1'b1;
    end
  end

  initial begin
    int   n;
    logic [2:0] dn;
    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b1;
    m.in_valid  = 1'b0;
    m.in_data   = '0;
    m.in_nbytes = '0;
    m.in_last   = 1'b0;
    m.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    @(negedge clk);
    chk("rst_in_ready", 32'(m.in_ready), 32'd1);
    chk("rst_out_valid", 32'(m.out_valid), 32'd0);
    chk("rst_cksum", m.out_checksum, 32'd0);
    @(posedge clk);
    #1;

    send_str("abc", 0, 32'h024D0127, 1'b1);
    @(negedge clk);
    chk("lat1", 32'(m.out_valid), 32'd1);
    drain();

    send_str("Wikipedia", 2, 32'h11E60398, 1'b1);
    drain();

    send_str("", 0, 32'h0000_0001, 1'b1);
    drain();
    send_str("abc", 0, 32'h024D0127, 1'b1);
    drain();

    m.out_ready = 1'b0;
    send_str("abc", 0, 32'h024D0127, 1'b1);
    m.in_valid  = 1'b1;
    m.in_data   = 32'h007A7978;
    m.in_nbytes = 3'd3;
    m.in_last   = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("hold_valid", 32'(m.out_valid), 32'd1);
      chk("hold_cksum", m.out_checksum,
          32'h024D0127);
      chk("hold_in_ready", 32'(m.in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    m.in_valid  = 1'b0;
    m.in_last   = 1'b0;
    m.out_ready = 1'b1;
    drain();
    @(negedge clk);
    chk("release_in_ready", 32'(m.in_ready), 32'd1);
    @(posedge clk);
    #1;
    send_str("Wikipedia", 0, 32'h11E60398, 1'b1);
    drain();

    send_beat(32'h696B6957, 4, 1'b0, 0);
    send_beat(32'h69646570, 4, 1'b0, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_str("abc", 0, 32'h024D0127, 1'b1);
    drain();

    m.out_ready = 1'b0;
    send_str("abc", 0, 32'h0, 1'b0);
    @(negedge clk);
    chk("pend_valid", 32'(m.out_valid), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("drop_valid", 32'(m.out_valid), 32'd0);
    chk("drop_in_ready", 32'(m.in_ready), 32'd1);
    chk("drop_cksum", m.out_checksum, 32'd0);
    @(posedge clk);
    #1;
    m.out_ready = 1'b1;
    send_str("Wikipedia", 1, 32'h11E60398, 1'b1);
    drain();

    n = 0;
    dn = {g_long[2].done, g_long[1].done,
          g_long[0].done};
    while (dn != 3'b111 && n < 20000) begin
      @(posedge clk);
      n++;
      dn = {g_long[2].done, g_long[1].done,
            g_long[0].done};
    end
    chk("long_done", 32'(dn), 32'd7);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
